// File: rtl/audio_pwm_multi.sv
// ---------------------------------------------------------------------------
// audio_pwm_multi
//
// Multi-channel PWM / first-order delta-sigma audio DAC driver. Frames of
// CHANNELS samples arrive on a valid/ready stream. Each frame lands in a
// one-frame holding register. At each period boundary it moves into the
// active register that drives the outputs.
//
// Parameters
//   WIDTH     sample width; the PWM period is 2^WIDTH clocks
//   CHANNELS  number of output channels
//   SIGNED    1: samples are two's complement and are mapped to offset
//             binary by inverting the MSB; 0: samples are unsigned
//
// Ports
//   clk           clock
//   reset         synchronous, active-high reset
//   mode          0 = PWM, 1 = delta-sigma; taken only at period boundaries
//   s_valid       frame valid
//   s_ready       holding register empty
//   s_data        frame; channel c at bits [c*WIDTH +: WIDTH]
//   pwm_out       per-channel 1-bit output stream
//   period_start  one-cycle pulse in the first cycle of each period
//   underrun      sticky; a boundary found no new frame buffered
//
// Handshake: a frame transfers on every rising clk edge where
// s_valid && s_ready. s_ready depends only on registered state (and reset),
// never on s_valid. s_data must be stable whenever s_valid is high.
// ---------------------------------------------------------------------------
module audio_pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int SIGNED   = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [CHANNELS*WIDTH-1:0] s_data,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_start,
    output logic                      underrun
);

    localparam logic [WIDTH-1:0] MAX       = '1;
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] SIGN_FLIP = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic                      full_q, full_d;
    logic [CHANNELS*WIDTH-1:0] hold_q, hold_d;
    logic [CHANNELS*WIDTH-1:0] active_q, active_d;
    logic [CHANNELS*WIDTH-1:0] acc_q, acc_d;
    logic                      mode_q, mode_d;
    logic [CHANNELS-1:0]       pwm_q, pwm_d;
    logic                      ps_q, ps_d;
    logic                      ur_q, ur_d;

    logic                      boundary;
    logic                      accept;
    logic [CHANNELS*WIDTH-1:0] conv_data;
    logic [WIDTH-1:0]          act_c;
    logic [WIDTH-1:0]          acc_c;
    logic [WIDTH:0]            sum_c;

    assign boundary  = (cnt_q == MAX);
    // Gating with reset keeps s_ready low while reset is held. Once reset
    // drops, the empty holding register is offered in that same cycle.
    assign s_ready   = !full_q && !reset;
    assign accept    = s_valid && s_ready;
    assign conv_data = s_data ^ {CHANNELS{SIGN_FLIP}};

    always_comb begin
        cnt_d    = cnt_q + ONE;
        full_d   = full_q;
        hold_d   = hold_q;
        active_d = active_q;
        mode_d   = mode_q;
        ur_d     = ur_q;
        ps_d     = boundary;

        if (boundary) begin
            mode_d = mode;
            if (full_q) begin
                active_d = hold_q;
                full_d   = 1'b0;
            end else begin
                // The active frame is kept, so the last sample repeats.
                ur_d = 1'b1;
            end
        end

        // An accept in a boundary cycle can only happen when the holding
        // register was empty. That frame waits in holding for the next
        // boundary.
        if (accept) begin
            hold_d = conv_data;
            full_d = 1'b1;
        end
    end

    always_comb begin
        pwm_d = '0;
        acc_d = acc_q;
        act_c = '0;
        acc_c = '0;
        sum_c = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            act_c = active_q[c*WIDTH +: WIDTH];
            acc_c = acc_q[c*WIDTH +: WIDTH];
            sum_c = {1'b0, acc_c} + {1'b0, act_c};
            if (mode_q) begin
                pwm_d[c]                 = sum_c[WIDTH];
                acc_d[c*WIDTH +: WIDTH]  = sum_c[WIDTH-1:0];
            end else begin
                pwm_d[c] = (cnt_q < act_c);
            end
            // A mode change restarts every accumulator from zero. This makes
            // the first delta-sigma period produce exactly active[c] highs.
            if (boundary && (mode != mode_q)) begin
                acc_d[c*WIDTH +: WIDTH] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            full_q   <= 1'b0;
            hold_q   <= '0;
            active_q <= '0;
            acc_q    <= '0;
            mode_q   <= 1'b0;
            pwm_q    <= '0;
            ps_q     <= 1'b0;
            ur_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            hold_q   <= hold_d;
            active_q <= active_d;
            acc_q    <= acc_d;
            mode_q   <= mode_d;
            pwm_q    <= pwm_d;
            ps_q     <= ps_d;
            ur_q     <= ur_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign underrun     = ur_q;

endmodule

// File: tb/tb_audio_pwm_multi.sv
// ---------------------------------------------------------------------------
// tb_audio_pwm_multi
//
// Bench for audio_pwm_multi with WIDTH=8 and CHANNELS=2. Two instances share
// the clock, reset, mode and s_valid inputs:
//   dut_u  SIGNED=0, fed the raw frame
//   dut_s  SIGNED=1, fed the same frame with each channel MSB inverted
// Both instances must therefore produce identical outputs.
//
// Expected per-cycle output for a sample v in window slot i (0..255):
//   PWM          : i < v
//   delta-sigma  : floor((i+1)*v/256) - floor(i*v/256), accumulator from 0
// ---------------------------------------------------------------------------
module tb_audio_pwm_multi;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic        s_valid;
    logic [15:0] s_data;
    logic [15:0] s_data_s;
    logic        s_ready_u, s_ready_s;
    logic [1:0]  pwm_u, pwm_s;
    logic        ps_u, ps_s;
    logic        ur_u, ur_s;

    int total = 0;
    int bad   = 0;

    assign s_data_s = s_data ^ 16'h8080;

    always #5 clk = ~clk;

    audio_pwm_multi #(.WIDTH(W), .CHANNELS(2), .SIGNED(0)) dut_u (
        .clk(clk), .reset(reset), .mode(mode),
        .s_valid(s_valid), .s_ready(s_ready_u), .s_data(s_data),
        .pwm_out(pwm_u), .period_start(ps_u), .underrun(ur_u)
    );

    audio_pwm_multi #(.WIDTH(W), .CHANNELS(2), .SIGNED(1)) dut_s (
        .clk(clk), .reset(reset), .mode(mode),
        .s_valid(s_valid), .s_ready(s_ready_s), .s_data(s_data_s),
        .pwm_out(pwm_s), .period_start(ps_s), .underrun(ur_s)
    );

    typedef struct {
        logic [7:0] ch0;
        logic [7:0] ch1;
        logic       ds;
        int         exp_hi0;
        int         exp_hi1;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input int v, input int i, input logic ds);
        if (ds) return ((((i + 1) * v) >> 8) - ((i * v) >> 8)) != 0;
        return i < v;
    endfunction

    // Entered in the cycle where period_start is high. Samples the next 256
    // cycles, which carry the outputs for counter values 0..255.
    task automatic measure(input int v0, input int v1, input logic ds,
                           input int sw_at, input logic sw_val,
                           output int hi0, output int hi1, output int perr,
                           output int ps_bad, output int ur_mid, output int ur_end);
        logic e0, e1;
        hi0 = 0; hi1 = 0; perr = 0; ps_bad = 0; ur_mid = 0; ur_end = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) s_valid = 1'b0;
            if (i == sw_at) mode = sw_val;
            e0 = exp_bit(v0, i, ds);
            e1 = exp_bit(v1, i, ds);
            if (pwm_u[0]) hi0++;
            if (pwm_u[1]) hi1++;
            if (pwm_u[0] !== e0 || pwm_s[0] !== e0) perr++;
            if (pwm_u[1] !== e1 || pwm_s[1] !== e1) perr++;
            if (i < 255 && (ps_u !== 1'b0 || ps_s !== 1'b0)) ps_bad++;
            if (i == 255 && (ps_u !== 1'b1 || ps_s !== 1'b1)) ps_bad++;
            if (i == 0)   ur_mid = {ur_u, ur_s};
            if (i == 255) ur_end = {ur_u, ur_s};
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi0, hi1, perr, ps_bad, ur_mid, ur_end;
        int lo_cnt, ps_cnt, first_ps, hi_cnt;

        vecs[0] = '{8'hFF, 8'h00, 1'b0, 255,   0};
        vecs[1] = '{8'h80, 8'h01, 1'b0, 128,   1};
        vecs[2] = '{8'h01, 8'hFE, 1'b0,   1, 254};
        vecs[3] = '{8'h80, 8'h80, 1'b1, 128, 128};
        vecs[4] = '{8'h40, 8'hC0, 1'b1,  64, 192};
        vecs[5] = '{8'h03, 8'hFF, 1'b1,   3, 255};
        vecs[6] = '{8'hC0, 8'h40, 1'b0, 192,  64};

        // ---- reset state, with s_valid already high ----
        reset   = 1'b1;
        mode    = 1'b0;
        s_valid = 1'b1;
        s_data  = {8'h40, 8'hC0};
        repeat (3) @(posedge clk);
        #1;
        check("reset_pwm",   {pwm_u, pwm_s}, 0);
        check("reset_ps",    {ps_u, ps_s}, 0);
        check("reset_ur",    {ur_u, ur_s}, 0);
        check("reset_ready", {s_ready_u, s_ready_s}, 0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", {s_ready_u, s_ready_s}, 3);

        // ---- back-pressure: first accept on the first edge after reset ----
        lo_cnt = 0;
        ps_cnt = 0;
        for (int j = 1; j <= 255; j++) begin
            @(posedge clk);
            #1;
            if (j == 1) s_data = {vecs[0].ch1, vecs[0].ch0};
            if (s_ready_u === 1'b0 && s_ready_s === 1'b0) lo_cnt++;
            if (ps_u !== 1'b0 || ps_s !== 1'b0) ps_cnt++;
        end
        check("bp_ready_low_cycles", lo_cnt, 255);
        check("bp_no_early_pulse", ps_cnt, 0);
        @(posedge clk);
        #1;
        check("bp_ready_after_boundary", {s_ready_u, s_ready_s}, 3);
        check("bp_first_pulse", {ps_u, ps_s}, 3);

        // ---- first frame {ch1=0x40, ch0=0xC0}; vecs[0] accepted next edge ----
        measure(8'hC0, 8'h40, 1'b0, -1, 1'b0, hi0, hi1, perr, ps_bad, ur_mid, ur_end);
        check("duty_first_hi0", hi0, 192);
        check("duty_first_hi1", hi1, 64);
        check("duty_first_pattern", perr, 0);
        check("duty_first_ps", ps_bad, 0);
        check("duty_first_ur", ur_end, 0);

        // ---- table: frame k+1 is offered while frame k is measured ----
        for (int k = 0; k < 7; k++) begin
            s_valid = 1'b1;
            if (k < 6) begin
                s_data = {vecs[k+1].ch1, vecs[k+1].ch0};
                mode   = vecs[k+1].ds;
            end else begin
                s_data = {8'h80, 8'h80};
                mode   = 1'b0;
            end
            measure(vecs[k].ch0, vecs[k].ch1, vecs[k].ds, -1, 1'b0,
                    hi0, hi1, perr, ps_bad, ur_mid, ur_end);
            check($sformatf("vec%0d_hi0", k), hi0, vecs[k].exp_hi0);
            check($sformatf("vec%0d_hi1", k), hi1, vecs[k].exp_hi1);
            check($sformatf("vec%0d_pattern", k), perr, 0);
            check($sformatf("vec%0d_ps", k), ps_bad, 0);
            check($sformatf("vec%0d_ur", k), ur_end, 0);
        end

        // ---- underrun: 0x80 was the last frame supplied ----
        measure(8'h80, 8'h80, 1'b0, -1, 1'b0, hi0, hi1, perr, ps_bad, ur_mid, ur_end);
        check("ur_hold_hi0", hi0, 128);
        check("ur_hold_pattern", perr, 0);
        check("ur_before_second_boundary", ur_mid, 0);
        check("ur_at_second_boundary", ur_end, 3);

        // ---- mode switch mid-period: stays PWM until the boundary ----
        measure(8'h80, 8'h80, 1'b0, 100, 1'b1, hi0, hi1, perr, ps_bad, ur_mid, ur_end);
        check("sw_still_pwm_pattern", perr, 0);
        check("ur_sticky", ur_end, 3);
        check("sw_ps", ps_bad, 0);

        measure(8'h80, 8'h80, 1'b1, -1, 1'b0, hi0, hi1, perr, ps_bad, ur_mid, ur_end);
        check("sw_ds_toggle_pattern", perr, 0);
        check("sw_ds_hi1", hi1, 128);
        check("ur_sticky_ds", ur_end, 3);

        // ---- reset at counter value 100 ----
        repeat (100) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_reset_ready_low", {s_ready_u, s_ready_s}, 0);
        @(posedge clk);
        #1;
        check("mid_reset_pwm", {pwm_u, pwm_s}, 0);
        check("mid_reset_ps", {ps_u, ps_s}, 0);
        check("mid_reset_ur", {ur_u, ur_s}, 0);
        reset = 1'b0;
        mode  = 1'b0;
        #1;
        check("mid_reset_ready_after", {s_ready_u, s_ready_s}, 3);
        first_ps = 0;
        hi_cnt   = 0;
        for (int n = 1; n <= 256; n++) begin
            @(posedge clk);
            #1;
            if (first_ps == 0 && (ps_u !== 1'b0 || ps_s !== 1'b0)) first_ps = n;
            if (pwm_u !== 2'b00 || pwm_s !== 2'b00) hi_cnt++;
        end
        check("mid_reset_first_pulse_cycle", first_ps, 256);
        check("mid_reset_active_cleared", hi_cnt, 0);
        check("mid_reset_ur_new_boundary", {ur_u, ur_s}, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_pwm_multi.md
# audio_pwm_multi

Multi-channel, parametrised PWM / delta-sigma audio DAC driver. It accepts frames of `CHANNELS` samples over a valid/ready stream, double-buffers them, and applies them on period boundaries. Each output is a 1-bit pulse stream for an external RC filter or amplifier pin. It sits between the sample source (SD-card reader / FIFO) and the board audio pins, replacing the single-channel, unbuffered 8-bit PWM driver.

## Interface
- `WIDTH`, 8: sample width; PWM period is 2^WIDTH clocks.
- `CHANNELS`, 2: number of output channels.
- `SIGNED`, 0: 1 means samples are two's complement and are converted to offset binary by inverting the MSB; 0 means unsigned.

- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `mode`  in  1  0 = PWM, 1 = first-order delta-sigma; sampled only at period boundaries.
- `s_valid`  in  1  frame valid.
- `s_ready`  out  1  holding register empty; frame accepted when `s_valid && s_ready`.
- `s_data`  in  CHANNELS*WIDTH  frame; channel c occupies bits [c*WIDTH +: WIDTH].
- `pwm_out`  out  CHANNELS  per-channel 1-bit output.
- `period_start`  out  1  one-cycle pulse marking the first cycle of each period.
- `underrun`  out  1  sticky; a boundary occurred with no new frame buffered.

## Operation
- Shared `WIDTH`-bit counter, free-running 0 → 2^WIDTH−1 → 0. A boundary is the cycle in which counter == MAX.
- **Holding register (one frame) plus active register (one frame):**
  - Accept writes the holding register (after sign conversion) and sets `full`.
  - `s_ready = !full`, registered from state; it is never asserted while full.
- **At a boundary:**
  - If `full`: holding → active, `full` cleared. `s_ready` rises the next cycle.
  - If not `full`: active retains its value (last sample repeats) and `underrun` is set.
  - `mode` is latched into `mode_q`.
  - If `mode_q` changes, all delta-sigma accumulators clear to 0.
- **Accept on a boundary cycle while empty:** the frame goes to holding, not active. It is applied at the next boundary.
- **PWM (`mode_q` = 0):** `pwm_out[c] <= (counter < active[c])`.
  - Sample 0 gives constant low.
  - Sample MAX gives high for 2^WIDTH−1 of every 2^WIDTH cycles.
- **Delta-sigma (`mode_q` = 1):** per channel, a (WIDTH+1)-bit sum of acc[WIDTH−1:0] + active[c].
  - acc <= sum[WIDTH−1:0]; `pwm_out[c] <= sum[WIDTH]`.
  - Over any 2^WIDTH-cycle window the high count equals active[c] exactly, once the accumulator starts at 0.
- **`period_start`** <= (counter == MAX), so it is high in the cycle the counter reads 0 after a wrap. There is no pulse for the first period after reset.
- **`underrun`** clears only on reset.

## Timing
- **Reset values:**
  - counter 0, active all 0, holding empty, acc 0, `mode_q` 0.
  - `pwm_out` all 0, `period_start` 0, `underrun` 0.
  - `s_ready` 0 while reset is high, 1 from the first cycle after reset deasserts.
- **Reset mid-operation** discards holding, active and accumulators immediately; outputs return to 0 on the next edge.
- **Output latency:** `pwm_out` reflects counter value k one cycle after the counter holds k. Across the period, PWM high cycles are exactly active[c].
- **Sample latency:** a frame accepted in cycle t drives outputs from the period starting after the first boundary at or after t+1. Worst case is 2^WIDTH+1 cycles.
- **Channels** are cycle-aligned; all change active values on the same edge.
- **Throughput:** at most one frame per 2^WIDTH cycles. The source is back-pressured by `s_ready`.

## Test plan
- **PWM duty:** WIDTH=8, CHANNELS=2, SIGNED=0, mode=0. Send frame {ch1=0x40, ch0=0xC0} before the first boundary. Required: in the following period ch0 is high for 192 cycles and ch1 for 64, both starting the cycle after `period_start`.
- **Extremes:** send 0x00 and 0xFF. Required: constant low, and exactly one low cycle per 256 respectively. `underrun` stays 0 while a frame is supplied every period.
- **Back-pressure / double buffer:** hold `s_valid` high continuously. Required:
  - The first accept occurs the cycle after reset.
  - The second accept occurs one cycle after the next boundary.
  - `s_ready` stays low between those accepts, and no frame is lost.
- **Underrun:** supply one frame 0x80, then stop. Required: `underrun` goes to 1 at the second boundary, and the output keeps a 128/256 duty indefinitely.
- **Signed + delta-sigma:** SIGNED=1, mode=1, sample 0x00 (maps to 0x80). Required: `pwm_out` toggles 0,1,0,1… (128 highs per 256 cycles). Switching mode mid-period takes effect only at the next boundary, with accumulators cleared.
- **Reset mid-period:** assert reset at counter=100 for one cycle. Required:
  - All outputs are 0 the next cycle.
  - `s_ready` is 0 during reset and 1 the cycle after.
  - The counter restarts at 0.
  - No `period_start` pulse occurs until the counter next wraps.
